postfix_term_engine: RTL and testbench
======================================

Name: postfix_term_engine

Overview:
- Parametrised successor of the single-term postfix accumulator.
- Fetches postfix codes from an external program ROM starting at a run-time base address, and evaluates them on an internal register stack of parametrised depth.
- Evaluates term_count consecutive terms and sums their results through the shared FP ALU.
- Adds operand-fetch decoding through one unified decoder handshake, a true subtract, and overflow/underflow/illegal-op error reporting.
- Sits between the top-level controller and the shared ALU, decoders and ROM.

Parameters:
- DATA_WIDTH, 32, operand/result width (IEEE-754 single by default).
- CODE_WIDTH, 8, postfix code width; bits [CODE_WIDTH-1:CODE_WIDTH-2] give the class.
- STACK_DEPTH, 16, internal stack entries (>=2).
- PROG_ADDR_WIDTH, 10, program ROM address width.
- TERM_CNT_WIDTH, 8, width of term_count.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle start pulse, sampled in IDLE only
- prog_base  in  PROG_ADDR_WIDTH  address of first code
- term_count  in  TERM_CNT_WIDTH  number of terms to evaluate and sum
- prog_addr  out  PROG_ADDR_WIDTH  ROM address
- prog_data  in  CODE_WIDTH  ROM data, valid 1 cycle after prog_addr
- decode_start  out  1  one-cycle pulse to operand decoder
- decode_code  out  CODE_WIDTH  code being decoded
- decode_ready  in  1  decoder result valid
- decode_data  in  DATA_WIDTH  decoded operand
- alu_start  out  1  one-cycle pulse to ALU
- alu_op  out  3  000 exp, 001 mul, 010 div, 011 add
- operand_a  out  DATA_WIDTH  ALU operand a
- operand_b  out  DATA_WIDTH  ALU operand b
- alu_ready  in  1  ALU result valid
- alu_result  in  DATA_WIDTH  ALU result
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle completion pulse
- result  out  DATA_WIDTH  sum of all terms, held until next start
- error  out  1  sticky error flag, cleared on the next accepted start
- error_code  out  2  01 overflow, 10 underflow, 11 illegal op/final depth

Behaviour:
Reset:
- All outputs 0, sp=0, state IDLE.
- Asynchronous assertion mid-run aborts immediately; no done pulse is produced.

IDLE:
- On start: latch prog_base into pc and term_count into terms_left; clear acc, sp, error and error_code.
- If term_count==0: go to DONE with result=0.
- Otherwise: set busy and go to FETCH.
- start is ignored while busy.

FETCH:
- prog_addr<=pc, pc<=pc+1.
- Next state READ.
- pc wraps modulo 2^PROG_ADDR_WIDTH.

READ:
- Sample prog_data into code.
- All-ones code: go to TERM_END.
- Class 10 (operator): go to OPN.
- Classes 00, 01, 11 (operand):
  - If sp==STACK_DEPTH: ERROR with code 01.
  - Else: decode_start=1 for one cycle, decode_code=code, go to DEC_WAIT.

DEC_WAIT:
- On decode_ready: stack[sp]<=decode_data, sp<=sp+1, go to FETCH.

OPN:
- If sp<2: ERROR with code 10.
- Low 3 bits 101..111: ERROR with code 11.
- Otherwise: operand_a=stack[sp-2], operand_b=stack[sp-1], alu_start pulse, go to OPN_WAIT.
- Op 100 is subtract: issue alu_op=011 with operand_b sign bit inverted. Other ops pass through unchanged.

OPN_WAIT:
- On alu_ready: stack[sp-2]<=alu_result, sp<=sp-1, go to FETCH.

TERM_END:
- If sp!=1: ERROR with code 11.
- First term: acc<=stack[0], go to NEXT.
- Later terms: operand_a=acc, operand_b=stack[0], alu_op=011, alu_start pulse, go to ACC_WAIT.

ACC_WAIT:
- On alu_ready: acc<=alu_result.

NEXT:
- sp<=0, terms_left<=terms_left-1.
- If terms_left becomes 0: go to DONE. Otherwise go to FETCH; the next term starts at the address following the end code.

DONE:
- result<=acc, done=1 for one cycle, busy<=0, go to IDLE.

ERROR:
- error<=1, error_code set, done pulse, busy<=0, result unchanged, go to IDLE.

Handshake rules:
- decode_ready and alu_ready are ignored outside their wait states.
- No timeout.

Test Plan:
- Codes used below: c2 is the constant code decoding to 0x40000000 (2.0); c3 decodes to 0x40400000 (3.0); mul=0x81; sub=0x84; END=0xFF.
- ROM [c2,c3,mul,END], term_count=1 -> one alu_start with op=001, a=0x40000000, b=0x40400000; ALU returns 0x40C00000; done with result=0x40C00000, error=0.
- Same program stored twice consecutively, term_count=2 -> one extra add with a=b=0x40C00000; result=0x41400000 (12.0).
- [c2,c3,sub,END] -> alu_op=011, operand_b=0xC0400000; ALU returns 0xBF800000; result=0xBF800000.
- STACK_DEPTH=2, program [c2,c2,c2] -> ERROR code 01 on the third operand, decode_start not pulsed for it; [c2,mul] -> ERROR code 10.
- term_count=0 -> done one cycle after start, result=0. Reset pulled low while in OPN_WAIT -> busy=0 and sp=0 immediately; a subsequent start runs normally.

Source files
------------

// File: rtl/postfix_term_engine.sv
// Multi-term postfix evaluator: fetches codes from a program ROM, runs them
// on an internal register stack and sums term results through a shared ALU.
//
// Ports:
//   clock, reset(async, active-low)
//   start, prog_base, term_count         : run request (sampled in IDLE)
//   prog_addr / prog_data                : program ROM, data valid in READ
//   decode_start/code/ready/data         : operand decoder handshake
//   alu_start/op, operand_a/b            : ALU request (op 000 exp,
//   alu_ready, alu_result                :   001 mul, 010 div, 011 add)
//   busy, done, result                   : run status and summed result
//   error, error_code                    : 01 ovf, 10 unf, 11 illegal/depth
module postfix_term_engine #(
  parameter int DATA_WIDTH      = 32,
  parameter int CODE_WIDTH      = 8,
  parameter int STACK_DEPTH     = 16,
  parameter int PROG_ADDR_WIDTH = 10,
  parameter int TERM_CNT_WIDTH  = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [PROG_ADDR_WIDTH-1:0] prog_base,
  input  logic [TERM_CNT_WIDTH-1:0]  term_count,
  output logic [PROG_ADDR_WIDTH-1:0] prog_addr,
  input  logic [CODE_WIDTH-1:0]      prog_data,
  output logic                       decode_start,
  output logic [CODE_WIDTH-1:0]      decode_code,
  input  logic                       decode_ready,
  input  logic [DATA_WIDTH-1:0]      decode_data,
  output logic                       alu_start,
  output logic [2:0]                 alu_op,
  output logic [DATA_WIDTH-1:0]      operand_a,
  output logic [DATA_WIDTH-1:0]      operand_b,
  input  logic                       alu_ready,
  input  logic [DATA_WIDTH-1:0]      alu_result,
  output logic                       busy,
  output logic                       done,
  output logic [DATA_WIDTH-1:0]      result,
  output logic                       error,
  output logic [1:0]                 error_code
);

  localparam int SPW   = $clog2(STACK_DEPTH + 1);
  localparam int SLOTS = 1 << SPW;
  localparam int PAW   = PROG_ADDR_WIDTH;
  localparam int TCW   = TERM_CNT_WIDTH;
  localparam int DW    = DATA_WIDTH;
  localparam int CW    = CODE_WIDTH;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_READ,
    S_DEC_WAIT,
    S_OPN,
    S_OPN_WAIT,
    S_TERM_END,
    S_ACC_WAIT,
    S_NEXT,
    S_DONE,
    S_ERROR
  } state_t;

  state_t          state;
  logic [PAW-1:0]  pc;
  logic [TCW-1:0]  terms_left;
  logic [2:0]      op_code;
  logic [SPW-1:0]  sp;
  logic [DW-1:0]   stack [SLOTS];
  logic [DW-1:0]   acc;
  logic            first_term;
  logic [1:0]      err_kind;

  logic [1:0]      cls;
  logic            end_code;
  logic            depth_full;
  logic            terms_last;
  logic [SPW-1:0]  sp_m1;
  logic [SPW-1:0]  sp_m2;
  logic [DW-1:0]   top_a;
  logic [DW-1:0]   top_b;
  logic [DW-1:0]   b_neg;
  logic            is_sub;

  assign cls        = prog_data[CW-1:CW-2];
  assign end_code   = &prog_data;
  assign depth_full = (sp == SPW'(STACK_DEPTH));
  assign terms_last = (terms_left == TCW'(1));
  assign sp_m1      = sp - SPW'(1);
  assign sp_m2      = sp - SPW'(2);
  assign top_a      = stack[sp_m2];
  assign top_b      = stack[sp_m1];
  // subtract is an add with the second operand's sign flipped
  assign b_neg      = {~top_b[DW-1], top_b[DW-2:0]};
  assign is_sub     = (op_code == 3'b100);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      pc           <= '0;
      terms_left   <= '0;
      op_code      <= '0;
      sp           <= '0;
      acc          <= '0;
      first_term   <= 1'b0;
      err_kind     <= '0;
      prog_addr    <= '0;
      decode_start <= 1'b0;
      decode_code  <= '0;
      alu_start    <= 1'b0;
      alu_op       <= '0;
      operand_a    <= '0;
      operand_b    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result       <= '0;
      error        <= 1'b0;
      error_code   <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        stack[i] <= '0;
      end
    end else begin
      decode_start <= 1'b0;
      alu_start    <= 1'b0;
      done         <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            pc         <= prog_base;
            terms_left <= term_count;
            acc        <= '0;
            sp         <= '0;
            error      <= 1'b0;
            error_code <= '0;
            first_term <= 1'b1;
            if (term_count == '0) begin
              state <= S_DONE;
            end else begin
              busy  <= 1'b1;
              state <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          prog_addr <= pc;
          pc        <= pc + PAW'(1);
          state     <= S_READ;
        end
        S_READ: begin
          op_code <= prog_data[2:0];
          unique case (1'b1)
            end_code:       state <= S_TERM_END;
            (cls == 2'b10): state <= S_OPN;
            default: begin
              if (depth_full) begin
                err_kind <= 2'b01;
                state    <= S_ERROR;
              end else begin
                decode_start <= 1'b1;
                decode_code  <= prog_data;
                state        <= S_DEC_WAIT;
              end
            end
          endcase
        end
        S_DEC_WAIT: begin
          if (decode_ready) begin
            stack[sp] <= decode_data;
            sp        <= sp + SPW'(1);
            state     <= S_FETCH;
          end
        end
        S_OPN: begin
          if (sp < SPW'(2)) begin
            err_kind <= 2'b10;
            state    <= S_ERROR;
          end else if (op_code >= 3'd5) begin
            err_kind <= 2'b11;
            state    <= S_ERROR;
          end else begin
            operand_a <= top_a;
            operand_b <= is_sub ? b_neg : top_b;
            alu_op    <= is_sub ? 3'b011 : op_code;
            alu_start <= 1'b1;
            state     <= S_OPN_WAIT;
          end
        end
        S_OPN_WAIT: begin
          if (alu_ready) begin
            stack[sp_m2] <= alu_result;
            sp           <= sp_m1;
            state        <= S_FETCH;
          end
        end
        S_TERM_END: begin
          if (sp != SPW'(1)) begin
            err_kind <= 2'b11;
            state    <= S_ERROR;
          end else if (first_term) begin
            acc   <= stack[0];
            state <= S_NEXT;
          end else begin
            operand_a <= acc;
            operand_b <= stack[0];
            alu_op    <= 3'b011;
            alu_start <= 1'b1;
            state     <= S_ACC_WAIT;
          end
        end
        S_ACC_WAIT: begin
          if (alu_ready) begin
            acc   <= alu_result;
            state <= S_NEXT;
          end
        end
        S_NEXT: begin
          sp         <= '0;
          terms_left <= terms_left - TCW'(1);
          first_term <= 1'b0;
          state      <= terms_last ? S_DONE : S_FETCH;
        end
        S_DONE: begin
          result <= acc;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
        S_ERROR: begin
          error      <= 1'b1;
          error_code <= err_kind;
          done       <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_postfix_term_engine.sv
// Randomised scoreboard bench for postfix_term_engine with a
// queue-based reference evaluator, decoder/ALU responders and monitors.
module tb_postfix_term_engine;

  localparam int DW    = 32;
  localparam int CW    = 8;
  localparam int DEPTH = 4;
  localparam int PAW   = 10;
  localparam int TCW   = 8;

  logic           clock = 1'b0;
  logic           reset;
  logic           start;
  logic [PAW-1:0] prog_base;
  logic [TCW-1:0] term_count;
  logic [PAW-1:0] prog_addr;
  logic [CW-1:0]  prog_data;
  logic           decode_start;
  logic [CW-1:0]  decode_code;
  logic           decode_ready;
  logic [DW-1:0]  decode_data;
  logic           alu_start;
  logic [2:0]     alu_op;
  logic [DW-1:0]  operand_a;
  logic [DW-1:0]  operand_b;
  logic           alu_ready;
  logic [DW-1:0]  alu_result;
  logic           busy;
  logic           done;
  logic [DW-1:0]  result;
  logic           error;
  logic [1:0]     error_code;

  postfix_term_engine #(
    .DATA_WIDTH(DW), .CODE_WIDTH(CW), .STACK_DEPTH(DEPTH),
    .PROG_ADDR_WIDTH(PAW), .TERM_CNT_WIDTH(TCW)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .prog_base(prog_base), .term_count(term_count),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .decode_start(decode_start), .decode_code(decode_code),
    .decode_ready(decode_ready), .decode_data(decode_data),
    .alu_start(alu_start), .alu_op(alu_op),
    .operand_a(operand_a), .operand_b(operand_b),
    .alu_ready(alu_ready), .alu_result(alu_result),
    .busy(busy), .done(done), .result(result),
    .error(error), .error_code(error_code)
  );

  always #5 clock = ~clock;

  logic [CW-1:0] rom [1 << PAW];
  assign prog_data = rom[prog_addr];

  typedef struct {
    logic [2:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } alu_req_t;

  typedef struct {
    logic [DW-1:0] res;
    logic          err;
    logic [1:0]    code;
  } done_t;

  alu_req_t      exp_alu [$];
  logic [CW-1:0] exp_dec [$];
  done_t         exp_done [$];
  logic [DW-1:0] last_result;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] dec(input logic [CW-1:0] c);
    if (c == 8'h02) return 32'h4000_0000;
    if (c == 8'h03) return 32'h4040_0000;
    return {c, ~c, c ^ 8'h5A, 8'hC3};
  endfunction

  // Stand-in FP unit: exact for the documented cases, a hash otherwise.
  function automatic logic [DW-1:0] alu_fn(input logic [2:0] op,
                                           input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    if (op == 3'd1 && a == 32'h4000_0000 && b == 32'h4040_0000)
      return 32'h40C0_0000;
    if (op == 3'd3 && a == 32'h40C0_0000 && b == 32'h40C0_0000)
      return 32'h4140_0000;
    if (op == 3'd3 && a == 32'h4000_0000 && b == 32'hC040_0000)
      return 32'hBF80_0000;
    return (a * 3) ^ {b[15:0], b[31:16]} ^ {op, 29'h0}
           ^ 32'h0123_4567;
  endfunction

  // Reference evaluation straight from the code stream semantics.
  task automatic model(input logic [PAW-1:0] base, input int tc);
    logic [PAW-1:0] pc;
    logic [DW-1:0]  acc;
    logic [DW-1:0]  stk [$];
    logic [CW-1:0]  c;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
    logic [2:0]     op;
    alu_req_t       r;
    done_t          d;
    int             err;
    pc  = base;
    acc = '0;
    err = 0;
    for (int t = 0; t < tc && err == 0; t++) begin
      stk.delete();
      forever begin
        c  = rom[pc];
        pc = pc + 1'b1;
        if (c == 8'hFF) begin
          if (stk.size() != 1) err = 3;
          else if (t == 0) acc = stk[0];
          else begin
            r = '{3'd3, acc, stk[0]};
            exp_alu.push_back(r);
            acc = alu_fn(3'd3, acc, stk[0]);
          end
          break;
        end else if (c[7:6] == 2'b10) begin
          if (stk.size() < 2) begin
            err = 2;
            break;
          end
          if (c[2:0] >= 3'd5) begin
            err = 3;
            break;
          end
          b  = stk[stk.size()-1];
          a  = stk[stk.size()-2];
          op = c[2:0];
          if (op == 3'd4) begin
            op    = 3'd3;
            b[31] = ~b[31];
          end
          r = '{op, a, b};
          exp_alu.push_back(r);
          void'(stk.pop_back());
          void'(stk.pop_back());
          stk.push_back(alu_fn(op, a, b));
        end else begin
          if (stk.size() == DEPTH) begin
            err = 1;
            break;
          end
          exp_dec.push_back(c);
          stk.push_back(dec(c));
        end
      end
    end
    if (err != 0) begin
      d = '{last_result, 1'b1, 2'(err)};
    end else begin
      last_result = acc;
      d = '{acc, 1'b0, 2'b00};
    end
    exp_done.push_back(d);
  endtask

  // Operand decoder responder with random latency.
  initial begin
    logic [CW-1:0] cl;
    decode_ready = 1'b0;
    decode_data  = '0;
    forever begin
      @(negedge clock);
      if (decode_start === 1'b1) begin
        if (exp_dec.size() == 0) begin
          check("dec_unexpected", {56'h0, decode_code}, 64'hFFFF);
        end else begin
          check("dec_code", {56'h0, decode_code},
                {56'h0, exp_dec.pop_front()});
        end
        cl = decode_code;
        repeat ($urandom_range(0, 2)) @(negedge clock);
        decode_data  = dec(cl);
        decode_ready = 1'b1;
        @(negedge clock);
        decode_ready = 1'b0;
      end
    end
  end

  // ALU responder with random latency.
  initial begin
    alu_req_t      e;
    logic [DW-1:0] rv;
    alu_ready  = 1'b0;
    alu_result = '0;
    forever begin
      @(negedge clock);
      if (alu_start === 1'b1) begin
        if (exp_alu.size() == 0) begin
          check("alu_unexpected", {61'h0, alu_op}, 64'hFF);
        end else begin
          e = exp_alu.pop_front();
          check("alu_op", {61'h0, alu_op}, {61'h0, e.op});
          check("alu_a", {32'h0, operand_a}, {32'h0, e.a});
          check("alu_b", {32'h0, operand_b}, {32'h0, e.b});
        end
        rv = alu_fn(alu_op, operand_a, operand_b);
        repeat ($urandom_range(0, 3)) @(negedge clock);
        alu_result = rv;
        alu_ready  = 1'b1;
        @(negedge clock);
        alu_ready = 1'b0;
      end
    end
  end

  // Completion monitor.
  initial begin
    done_t d;
    forever begin
      @(negedge clock);
      if (done === 1'b1) begin
        if (exp_done.size() == 0) begin
          check("done_unexpected", 64'h1, 64'h0);
        end else begin
          d = exp_done.pop_front();
          check("result", {32'h0, result}, {32'h0, d.res});
          check("error", {63'h0, error}, {63'h0, d.err});
          check("error_code", {62'h0, error_code}, {62'h0, d.code});
          check("busy_at_done", {63'h0, busy}, 64'h0);
        end
      end
    end
  end

  task automatic load(input logic [PAW-1:0] base,
                      input logic [CW-1:0] codes [$]);
    logic [PAW-1:0] p;
    p = base;
    foreach (codes[i]) begin
      rom[p] = codes[i];
      p = p + 1'b1;
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (done !== 1'b1 && n < 3000);
    if (done !== 1'b1) check("timeout", 64'h0, 64'h1);
  endtask

  task automatic run(input logic [PAW-1:0] base, input int tc);
    int n;
    model(base, tc);
    @(negedge clock);
    prog_base  = base;
    term_count = TCW'(tc);
    start      = 1'b1;
    @(negedge clock);
    start = 1'b0;
    if (tc != 0) begin
      check("busy_run", {63'h0, busy}, 64'h1);
      // a start while busy must be ignored
      term_count = '0;
      start      = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    wait_done(n);
    if (tc == 0) check("zero_latency", n, 1);
    @(negedge clock);
    check("alu_q_left", exp_alu.size(), 0);
    check("dec_q_left", exp_dec.size(), 0);
  endtask

  function automatic logic [CW-1:0] rand_operand();
    logic [CW-1:0] v;
    logic [1:0]    k;
    k = 2'($urandom_range(0, 2));
    v = {(k == 2'd2) ? 2'b11 : k, 6'($urandom_range(0, 63))};
    if (v == 8'hFF) v = 8'hC1;
    return v;
  endfunction

  function automatic logic [CW-1:0] rand_op();
    return {2'b10, 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 4))};
  endfunction

  task automatic gen(input logic [PAW-1:0] base, input int tc);
    logic [PAW-1:0] p;
    int sp;
    int steps;
    p = base;
    for (int t = 0; t < tc; t++) begin
      sp    = 0;
      steps = $urandom_range(1, 7);
      for (int s = 0; s < steps; s++) begin
        if (sp < 2 || (sp < DEPTH && $urandom_range(0, 1) == 1)) begin
          rom[p] = rand_operand();
          sp++;
        end else begin
          rom[p] = rand_op();
          sp--;
        end
        p = p + 1'b1;
      end
      while (sp > 1) begin
        rom[p] = rand_op();
        p = p + 1'b1;
        sp--;
      end
      rom[p] = 8'hFF;
      p = p + 1'b1;
    end
    if ($urandom_range(0, 7) == 0)
      rom[base + PAW'($urandom_range(0, 5))] =
        8'($urandom_range(0, 255));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    logic [CW-1:0] prg [$];
    for (int i = 0; i < (1 << PAW); i++) rom[i] = 8'hFF;
    last_result = '0;
    start      = 1'b0;
    prog_base  = '0;
    term_count = '0;
    reset      = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_done", {63'h0, done}, 64'h0);
    check("rst_result", {32'h0, result}, 64'h0);
    check("rst_error", {61'h0, error, error_code}, 64'h0);
    check("rst_strobes", {62'h0, alu_start, decode_start}, 64'h0);
    reset = 1'b1;
    @(negedge clock);

    prg = '{8'h02, 8'h03, 8'h81, 8'hFF};
    load(0, prg);
    run(0, 1);
    check("mul_result", {32'h0, result}, 64'h40C0_0000);

    prg = '{8'h02, 8'h03, 8'h81, 8'hFF,
            8'h02, 8'h03, 8'h81, 8'hFF};
    load(16, prg);
    run(16, 2);
    check("two_terms", {32'h0, result}, 64'h4140_0000);

    prg = '{8'h02, 8'h03, 8'h84, 8'hFF};
    load(32, prg);
    run(32, 1);
    check("sub_result", {32'h0, result}, 64'hBF80_0000);

    prg = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'hFF};
    load(48, prg);
    run(48, 1);
    prg = '{8'h02, 8'h81, 8'hFF};
    load(64, prg);
    run(64, 1);
    prg = '{8'h02, 8'h02, 8'h85, 8'hFF};
    load(80, prg);
    run(80, 1);
    prg = '{8'h02, 8'h02, 8'hFF};
    load(96, prg);
    run(96, 1);
    run(112, 0);
    prg = '{8'h02, 8'h03, 8'h81, 8'hFF};
    load(10'd1022, prg);
    run(10'd1022, 1);

    // abort a run while the ALU request is outstanding
    prg = '{8'h02, 8'h03, 8'h81, 8'hFF};
    load(128, prg);
    model(128, 1);
    @(negedge clock);
    prog_base  = 128;
    term_count = 8'd1;
    start      = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (alu_start !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("abort_reach", {63'h0, alu_start}, 64'h1);
    reset = 1'b0;
    #1;
    check("abort_busy", {63'h0, busy}, 64'h0);
    check("abort_sp", {59'h0, dut.sp}, 64'h0);
    check("abort_done", {63'h0, done}, 64'h0);
    exp_done.delete();
    exp_alu.delete();
    exp_dec.delete();
    last_result = '0;
    repeat (6) @(negedge clock);
    check("abort_result", {32'h0, result}, 64'h0);
    reset = 1'b1;
    @(negedge clock);
    run(128, 1);
    check("after_abort", {32'h0, result}, 64'h40C0_0000);

    for (int k = 0; k < 40; k++) begin
      logic [PAW-1:0] base;
      int tc;
      base = PAW'($urandom_range(0, (1 << PAW) - 1));
      tc   = $urandom_range(0, 4);
      gen(base, tc);
      run(base, tc);
    end

    repeat (5) @(negedge clock);
    check("done_q_left", exp_done.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
